// File: rtl/mdc_r2_stage.sv
// Radix-2 DIF multi-path delay commutator stage: delay/commutate/delay, butterfly,
// then twiddle multiply on the difference path. Sequencing comes from an internal pair counter.
module mdc_r2_stage #(
    parameter int WIDTH = 9,
    parameter int DELAY = 2,
    parameter int TW_W  = 9,
    parameter int FRAC  = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sync,
    input  logic                       scale_en,
    input  logic                       mul_en,
    input  logic signed [WIDTH-1:0]    in_up_re,
    input  logic signed [WIDTH-1:0]    in_up_im,
    input  logic signed [WIDTH-1:0]    in_lo_re,
    input  logic signed [WIDTH-1:0]    in_lo_im,
    output logic [$clog2(DELAY)-1:0]   tw_addr,
    input  logic signed [TW_W-1:0]     tw_re,
    input  logic signed [TW_W-1:0]     tw_im,
    output logic                       out_valid,
    output logic signed [WIDTH-1:0]    out_up_re,
    output logic signed [WIDTH-1:0]    out_up_im,
    output logic signed [WIDTH-1:0]    out_lo_re,
    output logic signed [WIDTH-1:0]    out_lo_im
);
    localparam int AW = $clog2(DELAY);
    localparam int CW = AW + 1;
    localparam int BW = WIDTH + 1;
    localparam int PW = WIDTH + TW_W + 2;
    localparam logic signed [BW-1:0] ONE_B = BW'(1);
    localparam logic signed [PW-1:0] RND   = PW'(1) << (FRAC - 1);

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] x);
        logic [PW-WIDTH:0] top;
        top = x[PW-1:WIDTH-1];
        if (top == '0 || top == '1) sat = x[WIDTH-1:0];
        else if (x[PW-1])           sat = {1'b1, {(WIDTH-1){1'b0}}};
        else                        sat = {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    // (t+1)>>>1 cannot overflow BW bits, so saturation happens only once at the end
    function automatic logic signed [WIDTH-1:0] bfly(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] y,
                                                     input logic sub, input logic scale);
        logic signed [BW-1:0] t;
        t = sub ? (BW'(x) - BW'(y)) : (BW'(x) + BW'(y));
        if (scale) t = (t + ONE_B) >>> 1;
        bfly = sat(PW'(t));
    endfunction

    // index [1] = imaginary, [0] = real
    logic [DELAY-1:0][1:0][WIDTH-1:0] dl_lo_q, dl_lo_d, dl_up_q, dl_up_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_eff;
    logic             primed_q, primed_d, primed_eff, sel;
    logic             out_valid_q, out_valid_d;
    logic [1:0][WIDTH-1:0] up_q, up_d, lo_q, lo_d;
    logic [1:0][WIDTH-1:0] in_up, in_lo, dl, com_up, com_l, a, s, d;
    logic signed [WIDTH-1:0] d_re, d_im;
    logic signed [PW-1:0]    pr, pi;

    always_comb begin
        cnt_eff    = in_sync ? '0 : cnt_q;
        sel        = cnt_eff[AW];
        tw_addr    = cnt_eff[AW-1:0];
        primed_eff = (primed_q & ~in_sync) | (cnt_eff == CW'(DELAY - 1));
        in_up      = {in_up_im, in_up_re};
        in_lo      = {in_lo_im, in_lo_re};
        dl         = dl_lo_q[DELAY-1];
        com_up     = sel ? dl : in_up;
        com_l      = sel ? in_up : dl;
        a          = dl_up_q[DELAY-1];
        for (int k = 0; k < 2; k++) begin
            s[k] = bfly(a[k], com_l[k], 1'b0, scale_en);
            d[k] = bfly(a[k], com_l[k], 1'b1, scale_en);
        end
        d_re = d[0];
        d_im = d[1];
        pr = PW'(d_re) * PW'(tw_re) - PW'(d_im) * PW'(tw_im) + RND;
        pi = PW'(d_re) * PW'(tw_im) + PW'(d_im) * PW'(tw_re) + RND;

        cnt_d       = cnt_q;
        primed_d    = primed_q;
        dl_lo_d     = dl_lo_q;
        dl_up_d     = dl_up_q;
        up_d        = up_q;
        lo_d        = lo_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            cnt_d       = cnt_eff + CW'(1);
            primed_d    = primed_eff;
            dl_lo_d     = {dl_lo_q[DELAY-2:0], in_lo};
            dl_up_d     = {dl_up_q[DELAY-2:0], com_up};
            out_valid_d = primed_eff;
            if (primed_eff) begin
                up_d = s;
                lo_d = mul_en ? {sat(pi >>> FRAC), sat(pr >>> FRAC)} : d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            dl_lo_q     <= '0;
            dl_up_q     <= '0;
            up_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            dl_lo_q     <= dl_lo_d;
            dl_up_q     <= dl_up_d;
            up_q        <= up_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_up_re = up_q[0];
    assign out_up_im = up_q[1];
    assign out_lo_re = lo_q[0];
    assign out_lo_im = lo_q[1];
endmodule

// File: tb/tb_mdc_r2_stage.sv
// Directed, table-driven bench for mdc_r2_stage (DELAY=2, WIDTH=9, TW_W=9, FRAC=7).
module tb_mdc_r2_stage;
    localparam int WIDTH = 9, DELAY = 2, TW_W = 9, FRAC = 7;

    logic clk, rst, in_valid, in_sync, scale_en, mul_en;
    logic signed [WIDTH-1:0] in_up_re, in_up_im, in_lo_re, in_lo_im;
    logic [$clog2(DELAY)-1:0] tw_addr;
    logic signed [TW_W-1:0] tw_re, tw_im;
    logic out_valid;
    logic signed [WIDTH-1:0] out_up_re, out_up_im, out_lo_re, out_lo_im;

    mdc_r2_stage #(.WIDTH(WIDTH), .DELAY(DELAY), .TW_W(TW_W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
        .scale_en(scale_en), .mul_en(mul_en),
        .in_up_re(in_up_re), .in_up_im(in_up_im), .in_lo_re(in_lo_re), .in_lo_im(in_lo_im),
        .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_up_re(out_up_re), .out_up_im(out_up_im),
        .out_lo_re(out_lo_re), .out_lo_im(out_lo_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst, vld, sync, sc, mu;
        int   ur, ui, lr, li, twr, twi;
        logic ev;
        int   eur, eui, elr, eli, eta;  // eta < 0: tw_addr not checked
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];
    vec_t t3[8];

    function automatic vec_t mk(input logic r, input logic v, input logic sy, input logic sc,
                                input logic mu, input int ur, input int ui, input int lr,
                                input int li, input int twr, input int twi, input logic ev,
                                input int eur, input int eui, input int elr, input int eli,
                                input int eta);
        vec_t x;
        x.rst = r; x.vld = v; x.sync = sy; x.sc = sc; x.mu = mu;
        x.ur = ur; x.ui = ui; x.lr = lr; x.li = li; x.twr = twr; x.twi = twi;
        x.ev = ev; x.eur = eur; x.eui = eui; x.elr = elr; x.eli = eli; x.eta = eta;
        return x;
    endfunction

    task automatic chk(input string nm, input integer act, input integer exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; in_valid = v.vld; in_sync = v.sync; scale_en = v.sc; mul_en = v.mu;
        in_up_re = v.ur[WIDTH-1:0]; in_up_im = v.ui[WIDTH-1:0];
        in_lo_re = v.lr[WIDTH-1:0]; in_lo_im = v.li[WIDTH-1:0];
        tw_re = v.twr[TW_W-1:0]; tw_im = v.twi[TW_W-1:0];
        #1;
        if (v.eta >= 0) chk({tag, " tw_addr"}, tw_addr, v.eta);
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, out_valid, v.ev);
        chk({tag, " out_up_re"}, out_up_re, v.eur);
        chk({tag, " out_up_im"}, out_up_im, v.eui);
        chk({tag, " out_lo_re"}, out_lo_re, v.elr);
        chk({tag, " out_lo_im"}, out_lo_im, v.eli);
    endtask

    function automatic vec_t gap_of(input vec_t nxt, input vec_t prev);
        return mk(0, 0, 0, 1, 0, 77, -77, 77, -77, 127, 127, 0,
                  prev.eur, prev.eui, prev.elr, prev.eli, nxt.eta);
    endfunction

    initial begin
        vec_t z;
        rst = 1; in_valid = 1; in_sync = 0; scale_en = 0; mul_en = 0;
        in_up_re = 0; in_up_im = 0; in_lo_re = 0; in_lo_im = 0; tw_re = 0; tw_im = 0;
        z = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);

        // reset held with valid data present
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 99, -99, 99, -99, 5, 5, 0, 0, 0, 0, 0, -1));
        // constant U=L=10: first primed output is built from cleared delays, then 20/0
        tbl.push_back(mk(0, 1, 0, 0, 0, 10, 10, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 10, 10, 10, 10, 0, 0, 1, 0, 0, 0, 0, 1));
        for (int i = 2; i < 6; i++)
            tbl.push_back(mk(0, 1, 0, 0, 0, 10, 10, 10, 10, 0, 0, 1, 20, 20, 0, 0, i % 2));
        // twiddle -j on the difference path
        t3[0] = mk(0, 1, 0, 0, 1, 50, 0, 0, 0, 0, -128, 0, 0, 0, 0, 0, 0);
        t3[1] = mk(0, 1, 0, 0, 1, 50, 0, 0, 0, 0, -128, 1, 0, 0, 0, 0, 1);
        t3[2] = mk(0, 1, 0, 0, 1, -50, 0, 0, 0, 0, -128, 1, 0, 0, 0, -100, 0);
        t3[3] = mk(0, 1, 0, 0, 1, -50, 0, 0, 0, 0, -128, 1, 0, 0, 0, -100, 1);
        t3[4] = mk(0, 1, 0, 0, 1, 50, 0, 0, 0, 0, -128, 1, 0, 0, 0, 0, 0);
        t3[5] = mk(0, 1, 0, 0, 1, 50, 0, 0, 0, 0, -128, 1, 0, 0, 0, 0, 1);
        t3[6] = mk(0, 1, 0, 0, 1, -50, 0, 0, 0, 0, -128, 1, 0, 0, 0, -100, 0);
        t3[7] = mk(0, 1, 0, 0, 1, -50, 0, 0, 0, 0, -128, 1, 0, 0, 0, -100, 1);
        tbl.push_back(z);
        for (int i = 0; i < 8; i++) tbl.push_back(t3[i]);
        // same sequence with an idle cycle before every pair
        tbl.push_back(z);
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(gap_of(t3[i], (i == 0) ? z : t3[i-1]));
            tbl.push_back(t3[i]);
        end
        // saturation and scaling: 200+200 -> 255, scaled -> 200, 200-(-256) -> 255, -512 -> -256
        tbl.push_back(z);
        tbl.push_back(mk(0, 1, 0, 0, 0, 200, 0, 200, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 200, 0, 200, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 200, 0, 200, 0, 0, 0, 1, 255, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 200, 0, 200, 0, 0, 0, 1, 255, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 200, 0, 200, 0, 0, 0, 1, 200, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 200, 0, 200, 0, 0, 0, 1, 200, 0, 0, 0, 1));
        for (int i = 6; i < 10; i++)
            tbl.push_back(mk(0, 1, 0, 0, 0, -256, 0, -256, 0, 0, 0, 1, -56, 0, 255, 0, i % 2));
        for (int i = 10; i < 12; i++)
            tbl.push_back(mk(0, 1, 0, 0, 0, -256, 0, -256, 0, 0, 0, 1, -256, 0, 0, 0, i % 2));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // frame sync at cnt=3: sync pair forces tw_addr=0 and drops valid, then realigns
        apply(z, "sy_rst");
        apply(t3[0], "sy_p0");
        apply(t3[1], "sy_p1");
        apply(t3[2], "sy_p2");
        apply(mk(0, 1, 1, 0, 1, 50, 0, 0, 0, 0, -128, 0, 0, 0, 0, -100, 0), "sy_s0");
        apply(mk(0, 1, 0, 0, 1, 50, 0, 0, 0, 0, -128, 1, 0, 0, 0, 0, 1), "sy_s1");
        apply(mk(0, 1, 0, 0, 1, -50, 0, 0, 0, 0, -128, 1, 0, 0, 0, -100, 0), "sy_s2");
        apply(mk(0, 1, 0, 0, 1, -50, 0, 0, 0, 0, -128, 1, 0, 0, 0, -100, 1), "sy_s3");

        // reset mid-frame clears outputs; next pair restarts at cnt=0
        apply(mk(1, 1, 0, 0, 1, 50, 0, 0, 0, 0, -128, 0, 0, 0, 0, 0, -1), "mr_rst");
        apply(t3[0], "mr_p0");
        apply(t3[1], "mr_p1");
        apply(t3[2], "mr_p2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
